apb_regfile_slave: RTL

APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_regfile_slave_if.sv | 30 +++
 rtl/apb_regfile_slave.sv | 139 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: slave FSM state encoding, wait-counter sizing and
// helpers that derive strobe width and byte-offset bits from the data width.
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_slv_state_t;

  // Wait counter covers 0..15 wait states.
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int off_w(input int dw);
    return (dw <= 8) ? 0 : $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between a master and the register-file slave.
interface apb_regfile_slave_if
  import apb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 8
);
  localparam int SW = strb_w(DW);

  logic [AW-1:0] i_paddr;
  logic          i_psel;
  logic          i_penable;
  logic          i_pwrite;
  logic [DW-1:0] i_pwdata;
  logic [SW-1:0] i_pstrb;
  logic [DW-1:0] o_prdata;
  logic          o_pready;
  logic          o_pslverr;

  modport slave (
    input  i_paddr, i_psel, i_penable, i_pwrite, i_pwdata, i_pstrb,
    output o_prdata, o_pready, o_pslverr
  );

  modport master (
    output i_paddr, i_psel, i_penable, i_pwrite, i_pwdata, i_pstrb,
    input  o_prdata, o_pready, o_pslverr
  );

endinterface

// File: rtl/apb_regfile_slave.sv
// APB register-file slave: NREG byte-enabled registers, register 0 is a
// read-only ID, programmable wait states, error response on bad accesses.
//
// state     | meaning
// ST_IDLE   | no transfer; waiting for a setup phase (psel=1, penable=0)
// ST_ACCESS | access phase; counting wait states, completes when cnt reaches 0
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int          DW     = 32,
  parameter int          AW     = 8,
  parameter int          NREG   = 16,
  parameter int          WAIT   = 1,
  parameter logic [31:0] ID_VAL = 32'hA9B0_0001
) (
  input  logic              pclk,
  input  logic              presetn,
  apb_regfile_slave_if.slave bus,
  output logic [NREG*DW-1:0] o_regs,
  output logic [NREG-1:0]    o_wr_pulse
);

  localparam int SW = strb_w(DW);
  localparam int OW = off_w(DW);
  localparam int IW = AW - OW;

  apb_slv_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]     idx;
  logic [32:0]       idx_ext;
  logic              misalign;
  logic              err;
  logic              done;
  logic              wr_en;
  logic [NREG-1:0]   hit;
  logic [DW-1:0]     rd_val;
  logic [NREG*DW-1:0] regs_flat;

  assign idx     = bus.i_paddr[AW-1:OW];
  assign idx_ext = 33'(idx);

  if (OW > 0) begin : g_off
    assign misalign = |bus.i_paddr[OW-1:0];
  end else begin : g_nooff
    assign misalign = 1'b0;
  end

  // Register 0 is a constant; only a write to it is an error, reads are fine.
  assign err   = (idx_ext >= 33'(NREG)) || misalign ||
                 (bus.i_pwrite && (idx_ext == 33'd0));
  assign done  = (state_q == ST_ACCESS) && bus.i_psel && bus.i_penable &&
                 (cnt_q == '0);
  assign wr_en = done && bus.i_pwrite && !err;

  // One-hot decode of the register index
  always_comb begin
    hit = '0;
    for (int k = 0; k < NREG; k++) begin
      hit[k] = (idx_ext == 33'(k));
    end
  end

  // Read mux over the flat register image
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NREG; k++) begin
      if (hit[k]) rd_val = regs_flat[k*DW +: DW];
    end
  end

  assign regs_flat[DW-1:0] = DW'(ID_VAL);

  for (genvar k = 1; k < NREG; k++) begin : g_reg
    for (genvar b = 0; b < SW; b++) begin : g_byte
      logic [7:0] byte_q;

      // Byte flop, loaded only on a good write completion with its strobe set
      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          byte_q <= 8'h00;
        end else if (wr_en && hit[k] && bus.i_pstrb[b]) begin
          byte_q <= bus.i_pwdata[b*8 +: 8];
        end
      end

      assign regs_flat[k*DW + b*8 +: 8] = byte_q;
    end
  end

  assign o_regs = regs_flat;

  // Write pulse follows the update edge, so the new value is visible with it
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      o_wr_pulse <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        o_wr_pulse[k] <= wr_en && hit[k];
      end
    end
  end

  // FSM state and wait counter
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait counting and the combinational response
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.o_pready  = done;
    bus.o_pslverr = done && err;
    bus.o_prdata  = (done && !bus.i_pwrite && !err) ? rd_val : '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_psel && !bus.i_penable) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_W'(WAIT);
        end
      end
      ST_ACCESS: begin
        if (!bus.i_psel || done) begin
          state_d = ST_IDLE;
        end else if (bus.i_penable) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
